sp_forward_unit_n: RTL and testbench

//  Parametrised, registered stack-pointer forwarding unit. Successor to the 2-source SP forwarding unit.

---
 rtl/sp_forward_unit_n.sv | 164 ++++++++++++++++
 tb/tb_sp_forward_unit_n.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sp_forward_unit_n.sv
// sp_forward_unit_n
//   Registered stack-pointer forwarding unit. Picks the youngest in-flight SP
//   update among N_SRC pipeline stages for the stage that reads SP. The result
//   is registered with one cycle of latency. The unit supports stall-hold and
//   flush, and keeps a saturating count of forward hits.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset; overrides every other input
//   enable        unit enable; 0 turns a would-be hit into a miss
//   stall         freezes every registered output; inputs are ignored
//   flush         clears forwarding state; wins over a simultaneous stall
//   sp_src        consumer stage requests SP this cycle
//   stack_op      per-source "this stage writes SP" flag, bit 0 = youngest
//   sp_value      packed source values, source i at [i*SP_W +: SP_W]
//   sp_fwd_value  registered forwarded SP
//   sp_fwd_hit    sp_fwd_value holds valid forwarded data
//   sp_fwd_sel    registered index of the winning source (0 on miss)
//   fwd_count     saturating count of registered hits since reset

// Per-source priority slot. Slots are chained from youngest to oldest. A slot
// wins when its stage writes SP and no younger stage does. Its value is masked
// to zero unless it wins, so the winning value can be recovered by OR-ing the
// outputs of all slots.
module sp_fwd_slot #(
   parameter int SP_W = 32
) (
   input  logic            op_i,
   input  logic            younger_any_i,
   input  logic [SP_W-1:0] value_i,
   output logic            win_o,
   output logic            any_o,
   output logic [SP_W-1:0] value_o
);
   assign win_o   = op_i & ~younger_any_i;
   assign any_o   = op_i | younger_any_i;
   assign value_o = value_i & {SP_W{win_o}};
endmodule

module sp_forward_unit_n #(
   parameter int SP_W      = 32,
   parameter int N_SRC     = 2,
   parameter int SEL_W     = 1,
   parameter int CNT_W     = 16,
   parameter bit MISS_ZERO = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  sp_src,
   input  logic [N_SRC-1:0]      stack_op,
   input  logic [N_SRC*SP_W-1:0] sp_value,
   output logic [SP_W-1:0]       sp_fwd_value,
   output logic                  sp_fwd_hit,
   output logic [SEL_W-1:0]      sp_fwd_sel,
   output logic [CNT_W-1:0]      fwd_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // All registered state lives in one struct so that the stall, flush and
   // update paths each show which fields they change.
   typedef struct packed {
      state_e           state;
      logic             prev_fwd;   // HOLD was entered from FWD
      logic [SP_W-1:0]  value;
      logic [SEL_W-1:0] sel;
      logic [CNT_W-1:0] cnt;
   } fwd_state_t;

   fwd_state_t out_q, out_d;

   // ---------------- priority select ----------------
   logic [N_SRC:0]                 any_chain;
   logic [N_SRC-1:0]               win;
   logic [N_SRC-1:0][SP_W-1:0]     slot_val;
   logic [SP_W-1:0]                win_value;
   logic [SEL_W-1:0]               win_sel;
   logic                           req;

   assign any_chain[0] = 1'b0;

   for (genvar i = 0; i < N_SRC; i++) begin : g_slot
      sp_fwd_slot #(.SP_W(SP_W)) u_slot (
         .op_i          (stack_op[i]),
         .younger_any_i (any_chain[i]),
         .value_i       (sp_value[i*SP_W +: SP_W]),
         .win_o         (win[i]),
         .any_o         (any_chain[i+1]),
         .value_o       (slot_val[i])
      );
   end

   // At most one bit of win is set, so OR-reduction acts as a one-hot mux
   // and encoder.
   always_comb begin
      win_value = '0;
      win_sel   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         win_value = win_value | slot_val[i];
         if (win[i]) win_sel = win_sel | SEL_W'(i);
      end
   end

   // The end of the chain is |stack_op.
   assign req = enable & sp_src & any_chain[N_SRC];

   // ---------------- next state ----------------
   always_comb begin
      out_d = out_q;
      if (flush) begin
         out_d.state    = ST_IDLE;
         out_d.prev_fwd = 1'b0;
         out_d.sel      = '0;
         if (MISS_ZERO) out_d.value = '0;
      end else if (stall) begin
         // A stall that lasts several cycles stays in HOLD. Only the first
         // stall cycle records where the unit came from.
         if (out_q.state != ST_HOLD) begin
            out_d.prev_fwd = (out_q.state == ST_FWD);
            out_d.state    = ST_HOLD;
         end
      end else if (req) begin
         out_d.state    = ST_FWD;
         out_d.prev_fwd = 1'b0;
         out_d.value    = win_value;
         out_d.sel      = win_sel;
         if (out_q.cnt != {CNT_W{1'b1}}) out_d.cnt = out_q.cnt + 1'b1;
      end else begin
         out_d.state    = ST_IDLE;
         out_d.prev_fwd = 1'b0;
         out_d.sel      = '0;
         if (MISS_ZERO) out_d.value = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q.state    <= ST_IDLE;
         out_q.prev_fwd <= 1'b0;
         out_q.value    <= '0;
         out_q.sel      <= '0;
         out_q.cnt      <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   // ---------------- outputs ----------------
   // Hit is decoded from registered state only. During HOLD it reflects the
   // state the unit was in when the stall began.
   assign sp_fwd_hit   = (out_q.state == ST_FWD) |
                         ((out_q.state == ST_HOLD) & out_q.prev_fwd);
   assign sp_fwd_value = out_q.value;
   assign sp_fwd_sel   = out_q.sel;
   assign fwd_count    = out_q.cnt;

endmodule

// File: tb/tb_sp_forward_unit_n.sv
module tb_sp_forward_unit_n;
   localparam int SP_W = 32, N_SRC = 3, SEL_W = 2, CNT_W = 4;

   logic                  clk = 1'b0;
   logic                  rst, enable, stall, flush, sp_src;
   logic [N_SRC-1:0]      stack_op;
   logic [N_SRC*SP_W-1:0] sp_value;
   logic [SP_W-1:0]       sp_fwd_value;
   logic                  sp_fwd_hit;
   logic [SEL_W-1:0]      sp_fwd_sel;
   logic [CNT_W-1:0]      fwd_count;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sp_forward_unit_n #(
      .SP_W(SP_W), .N_SRC(N_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W), .MISS_ZERO(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .stall(stall), .flush(flush),
      .sp_src(sp_src), .stack_op(stack_op), .sp_value(sp_value),
      .sp_fwd_value(sp_fwd_value), .sp_fwd_hit(sp_fwd_hit),
      .sp_fwd_sel(sp_fwd_sel), .fwd_count(fwd_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge. Outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vals(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
      sp_value = {v2, v1, v0};
   endtask

   task automatic chk_all(input string tag, input logic hit, input logic [31:0] val,
                          input logic [1:0] sel, input logic [3:0] cnt);
      chk({tag, ".hit"}, 64'(sp_fwd_hit),   64'(hit));
      chk({tag, ".val"}, 64'(sp_fwd_value), 64'(val));
      chk({tag, ".sel"}, 64'(sp_fwd_sel),   64'(sel));
      chk({tag, ".cnt"}, 64'(fwd_count),    64'(cnt));
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; enable = 1'b0; stall = 1'b0; flush = 1'b0; sp_src = 1'b0;
      stack_op = '0; sp_value = '0;
      #1;
      step(); step();
      chk_all("reset", 1'b0, 32'h0, 2'd0, 4'd0);
      rst = 1'b0;

      // 1. single source
      enable = 1'b1; sp_src = 1'b1; stack_op = 3'b010;
      set_vals(32'h0, 32'hAAAAAAAA, 32'h0);
      step();
      chk_all("single", 1'b1, 32'hAAAAAAAA, 2'd1, 4'd1);

      // 2. priority
      stack_op = 3'b111; set_vals(32'h11111111, 32'h22222222, 32'h33333333);
      step();
      chk_all("prio111", 1'b1, 32'h11111111, 2'd0, 4'd2);
      stack_op = 3'b110;
      step();
      chk_all("prio110", 1'b1, 32'h22222222, 2'd1, 4'd3);
      stack_op = 3'b100;
      step();
      chk_all("prio100", 1'b1, 32'h33333333, 2'd2, 4'd4);

      // 3. miss and disable
      stack_op = 3'b000;
      step();
      chk_all("miss", 1'b0, 32'h0, 2'd0, 4'd4);
      stack_op = 3'b001; enable = 1'b0;
      step();
      chk_all("disable", 1'b0, 32'h0, 2'd0, 4'd4);
      enable = 1'b1; sp_src = 1'b0;
      step();
      chk_all("no_src", 1'b0, 32'h0, 2'd0, 4'd4);

      // 4. stall / flush
      sp_src = 1'b1; stack_op = 3'b001; set_vals(32'h55555555, 32'h0, 32'h0);
      step();
      chk_all("pre_stall", 1'b1, 32'h55555555, 2'd0, 4'd5);
      stall = 1'b1; stack_op = 3'b100; set_vals(32'h0, 32'h0, 32'h77777777);
      for (int k = 0; k < 3; k++) begin
         step();
         chk_all("stall", 1'b1, 32'h55555555, 2'd0, 4'd5);
      end
      flush = 1'b1;
      step();
      chk_all("stall_flush", 1'b0, 32'h0, 2'd0, 4'd5);
      flush = 1'b0;
      // a stall that begins in IDLE keeps hit=0 even though a request is pending
      step();
      chk_all("stall_idle", 1'b0, 32'h0, 2'd0, 4'd5);
      stall = 1'b0; set_vals(32'h0, 32'h0, 32'h99999999);
      step();
      chk_all("unstall", 1'b1, 32'h99999999, 2'd2, 4'd6);
      // flush without stall while in FWD
      flush = 1'b1;
      step();
      chk_all("flush", 1'b0, 32'h0, 2'd0, 4'd6);
      flush = 1'b0;

      // 5. saturation
      stack_op = 3'b010; set_vals(32'h0, 32'h12345678, 32'h0);
      for (int k = 0; k < 20; k++) step();
      chk_all("sat", 1'b1, 32'h12345678, 2'd1, 4'd15);
      step();
      chk("sat_hold.cnt", 64'(fwd_count), 64'd15);
      rst = 1'b1;
      step();
      chk_all("rst_end", 1'b0, 32'h0, 2'd0, 4'd0);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
